// File: rtl/unit_control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction classes,
// flag-update classes, register-bank write-data selects and the latched control bundle.
package unit_control_pkg;

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5
    } state_e;

    localparam logic [2:0] TYPE_BR    = 3'b000;
    localparam logic [2:0] TYPE_ALU   = 3'b001;
    localparam logic [2:0] TYPE_CONST = 3'b010;
    localparam logic [2:0] TYPE_MEM   = 3'b100;
    localparam logic [2:0] TYPE_JMP   = 3'b110;
    localparam logic [2:0] TYPE_SYS   = 3'b111;

    localparam logic [2:0] WRF_NONE = 3'b000;
    localparam logic [2:0] WRF_C1   = 3'b001;
    localparam logic [2:0] WRF_C2   = 3'b010;
    localparam logic [2:0] WRF_C3   = 3'b011;
    localparam logic [2:0] WRF_C4   = 3'b100;

    localparam logic [1:0] MXRB_PC  = 2'b00;
    localparam logic [1:0] MXRB_MEM = 2'b01;
    localparam logic [1:0] MXRB_ALU = 2'b10;

    localparam logic [2:0] TF_NONE = 3'b111;

    // ALU operation used to form branch and jump targets
    localparam logic [4:0] OP_TARGET = 5'b10011;

    typedef struct packed {
        logic [2:0] op_tf;
        logic       op_se;
        logic       s_mxse;
        logic       w_rb;
        logic       w_dm;
        logic [2:0] w_rf;
        logic [1:0] s_mxrb;
        logic       is_mem;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        op_tf:  TF_NONE,
        op_se:  1'b0,
        s_mxse: 1'b0,
        w_rb:   1'b0,
        w_dm:   1'b0,
        w_rf:   WRF_NONE,
        s_mxrb: MXRB_PC,
        is_mem: 1'b0
    };

endpackage

// File: rtl/unit_control_if.sv
// Instruction/handshake inputs and datapath control outputs of the control unit.
// The unit connects through the slave modport; the instruction source uses master.
interface unit_control_if #(
    parameter int unsigned OP_W  = 5,
    parameter int unsigned CNT_W = 16
);
    logic [2:0]       instr_type;
    logic [OP_W-1:0]  op;
    logic             IM_READY;
    logic             DM_READY;
    logic [OP_W-1:0]  OP_ALU;
    logic [2:0]       OP_TF;
    logic             OP_SE;
    logic             W_PC;
    logic             W_DM;
    logic             W_IM;
    logic             W_RB;
    logic [2:0]       W_RF;
    logic [1:0]       S_MXRB;
    logic             S_MXSE;
    logic             HALTED;
    logic             ILLEGAL;
    logic [CNT_W-1:0] INSTR_CNT;

    modport master (
        output instr_type, op, IM_READY, DM_READY,
        input  OP_ALU, OP_TF, OP_SE, W_PC, W_DM, W_IM, W_RB, W_RF, S_MXRB, S_MXSE,
        input  HALTED, ILLEGAL, INSTR_CNT
    );

    modport slave (
        input  instr_type, op, IM_READY, DM_READY,
        output OP_ALU, OP_TF, OP_SE, W_PC, W_DM, W_IM, W_RB, W_RF, S_MXRB, S_MXSE,
        output HALTED, ILLEGAL, INSTR_CNT
    );
endinterface

// File: rtl/unit_control_decode.sv
// Combinational decode of instruction class and operation into the control bundle,
// plus halt and illegal-class detection.
module unit_control_decode
    import unit_control_pkg::*;
#(
    parameter int unsigned OP_W    = 5,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input  logic [2:0]      instr_type,
    input  logic [OP_W-1:0] op,
    output logic [OP_W-1:0] op_alu,
    output ctrl_t           ctrl,
    output logic            halt,
    output logic            illegal
);

    logic [4:0] op5;
    logic [2:0] cond;

    assign op5  = op[4:0];
    assign cond = {op5[2], op5[3], op5[4]};

    always_comb begin
        op_alu  = '0;
        ctrl    = CTRL_DEFAULT;
        halt    = 1'b0;
        illegal = 1'b0;
        case (instr_type)
            TYPE_ALU: begin
                op_alu      = op;
                ctrl.w_rb   = 1'b1;
                ctrl.s_mxrb = MXRB_ALU;
                if (op5 == 5'b11111)        ctrl.w_rf = WRF_NONE;
                else if (op5 == 5'b10000)   ctrl.w_rf = WRF_C1;
                else if (op5[4:3] == 2'b01) ctrl.w_rf = WRF_C3;
                else if (op5[4:3] == 2'b00) ctrl.w_rf = WRF_C4;
                else                        ctrl.w_rf = WRF_C2;
            end
            TYPE_CONST: begin
                op_alu      = op;
                ctrl.op_se  = 1'b1;
                ctrl.w_rb   = 1'b1;
                ctrl.s_mxse = 1'b1;
                ctrl.s_mxrb = MXRB_ALU;
            end
            TYPE_MEM: begin
                ctrl.is_mem = 1'b1;
                ctrl.w_rb   = ~op5[4];
                ctrl.w_dm   = op5[4];
                ctrl.s_mxrb = MXRB_MEM;
            end
            TYPE_BR: begin
                op_alu      = OP_W'(OP_TARGET);
                ctrl.op_tf  = cond;
                ctrl.s_mxse = 1'b1;
            end
            TYPE_JMP: begin
                op_alu      = OP_W'(OP_TARGET);
                ctrl.op_tf  = cond;
                ctrl.s_mxrb = MXRB_PC;
                ctrl.w_rb   = (cond == 3'b011);  // jal links the return address
            end
            TYPE_SYS: begin
                if (op5 == HALT_OP) halt = 1'b1;
                else                illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/unit_control_mc.sv
// Multicycle control unit: IF/ID/EX/MEM/WB/HALT sequencing with memory ready handshakes,
// sticky illegal-class flag and a wrapping retired-instruction counter.
module unit_control_mc
    import unit_control_pkg::*;
#(
    parameter int unsigned OP_W    = 5,
    parameter int unsigned CNT_W   = 16,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input logic          CLK,
    input logic          RESET,
    unit_control_if.slave bus
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_dec;
    logic [OP_W-1:0]  op_alu_q, op_alu_dec;
    logic             halt_dec, illegal_dec;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic [OP_W-1:0]  op_alu;
    logic [2:0]       op_tf;
    logic             op_se, s_mxse, w_pc, w_dm, w_rb, halted;
    logic [2:0]       w_rf;
    logic [1:0]       s_mxrb;

    unit_control_decode #(
        .OP_W    (OP_W),
        .HALT_OP (HALT_OP)
    ) u_decode (
        .instr_type (bus.instr_type),
        .op         (bus.op),
        .op_alu     (op_alu_dec),
        .ctrl       (ctrl_dec),
        .halt       (halt_dec),
        .illegal    (illegal_dec)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIf;
            ctrl_q    <= CTRL_DEFAULT;
            op_alu_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StId) begin
                ctrl_q   <= ctrl_dec;
                op_alu_q <= op_alu_dec;
                if (illegal_dec) illegal_q <= 1'b1;
            end
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        op_alu  = '0;
        op_tf   = TF_NONE;
        op_se   = 1'b0;
        s_mxse  = 1'b0;
        w_pc    = 1'b0;
        w_dm    = 1'b0;
        w_rb    = 1'b0;
        w_rf    = WRF_NONE;
        s_mxrb  = MXRB_PC;
        halted  = 1'b0;
        // Outputs stay at defaults for the whole reset cycle, whatever the state.
        if (!RESET) begin
            case (state_q)
                StIf: begin
                    w_pc = bus.IM_READY;
                    if (bus.IM_READY) state_d = StId;
                end
                StId: begin
                    if (halt_dec)         state_d = StHalt;
                    else if (illegal_dec) state_d = StIf;
                    else                  state_d = StEx;
                end
                StEx: begin
                    op_alu  = op_alu_q;
                    op_tf   = ctrl_q.op_tf;
                    op_se   = ctrl_q.op_se;
                    s_mxse  = ctrl_q.s_mxse;
                    state_d = ctrl_q.is_mem ? StMem : StWb;
                end
                StMem: begin
                    op_alu = op_alu_q;
                    op_tf  = ctrl_q.op_tf;
                    op_se  = ctrl_q.op_se;
                    s_mxse = ctrl_q.s_mxse;
                    w_dm   = ctrl_q.w_dm;
                    if (bus.DM_READY) begin
                        // A store has nothing to write back and retires here.
                        if (ctrl_q.w_dm) begin
                            state_d = StIf;
                            retire  = 1'b1;
                        end else begin
                            state_d = StWb;
                        end
                    end
                end
                StWb: begin
                    s_mxrb  = ctrl_q.s_mxrb;
                    w_rf    = ctrl_q.w_rf;
                    w_rb    = ctrl_q.w_rb;
                    retire  = 1'b1;
                    state_d = StIf;
                end
                StHalt: halted = 1'b1;
                default: state_d = StIf;
            endcase
        end
    end

    assign bus.OP_ALU    = op_alu;
    assign bus.OP_TF     = op_tf;
    assign bus.OP_SE     = op_se;
    assign bus.W_PC      = w_pc;
    assign bus.W_DM      = w_dm;
    assign bus.W_IM      = 1'b0;
    assign bus.W_RB      = w_rb;
    assign bus.W_RF      = w_rf;
    assign bus.S_MXRB    = s_mxrb;
    assign bus.S_MXSE    = s_mxse;
    assign bus.HALTED    = halted;
    assign bus.ILLEGAL   = illegal_q & ~RESET;
    assign bus.INSTR_CNT = RESET ? '0 : cnt_q;

endmodule

// File: tb/tb_unit_control_mc.sv
// Directed and randomized bench for unit_control_mc; a second instance with a 2-bit
// counter shares the stimulus to exercise counter wrap.
module tb_unit_control_mc;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    unit_control_if #(.OP_W(5), .CNT_W(16)) bus ();
    unit_control_if #(.OP_W(5), .CNT_W(2))  bus2 ();

    assign bus2.instr_type = bus.instr_type;
    assign bus2.op         = bus.op;
    assign bus2.IM_READY   = bus.IM_READY;
    assign bus2.DM_READY   = bus.DM_READY;

    unit_control_mc #(.OP_W(5), .CNT_W(16), .HALT_OP(5'b11111)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    unit_control_mc #(.OP_W(5), .CNT_W(2), .HALT_OP(5'b11111)) dut2 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int retired  = 0;
    bit ill_seen = 1'b0;

    typedef struct packed {
        logic [4:0] alu;
        logic [2:0] tf;
        logic       se;
        logic       mxse;
        logic       rb;
        logic       dm;
        logic [2:0] rf;
        logic [1:0] mxrb;
        logic       mem;
        logic       halt;
        logic       bad;
    } exp_t;

    // Expected controls straight from the decode rules, keyed by class and op.
    function automatic exp_t model(input logic [2:0] t, input logic [4:0] o);
        exp_t e;
        logic [2:0] cond;
        cond = {o[2], o[3], o[4]};
        e = '0;
        e.tf = 3'b111;
        if (t == 3'b001) begin
            e.alu = o; e.rb = 1'b1; e.mxrb = 2'b10;
            if (o == 5'b11111)        e.rf = 3'b000;
            else if (o == 5'b10000)   e.rf = 3'b001;
            else if (o[4:3] == 2'b01) e.rf = 3'b011;
            else if (o[4:3] == 2'b00) e.rf = 3'b100;
            else                      e.rf = 3'b010;
        end else if (t == 3'b010) begin
            e.alu = o; e.se = 1'b1; e.rb = 1'b1; e.mxse = 1'b1; e.mxrb = 2'b10;
        end else if (t == 3'b100) begin
            e.mem = 1'b1; e.rb = ~o[4]; e.dm = o[4]; e.mxrb = 2'b01;
        end else if (t == 3'b000 || t == 3'b110) begin
            e.alu  = 5'b10011;
            e.tf   = cond;
            e.mxse = (t == 3'b000);
            e.rb   = (t == 3'b110) && (cond == 3'b011);
        end else if (t == 3'b111 && o == 5'b11111) begin
            e.halt = 1'b1;
        end else begin
            e.bad = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cnt16"}, 32'(bus.INSTR_CNT), 32'(retired % 65536));
        check({tag, "_cnt2"}, 32'(bus2.INSTR_CNT), 32'(retired % 4));
        check({tag, "_illegal"}, 32'(bus.ILLEGAL), 32'(ill_seen));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.IM_READY = 1'b1;
        bus.DM_READY = 1'b1;
        #1;
        check("rst_wpc", 32'(bus.W_PC), 0);
        check("rst_halted", 32'(bus.HALTED), 0);
        check("rst_tf", 32'(bus.OP_TF), 7);
        tick();
        rst = 1'b0;
        bus.IM_READY = 1'b0;
        bus.DM_READY = 1'b0;
        retired  = 0;
        ill_seen = 1'b0;
        #1;
        check("post_rst_wpc", 32'(bus.W_PC), 0);
        check("post_rst_wdm", 32'(bus.W_DM), 0);
        check("post_rst_wrb", 32'(bus.W_RB), 0);
        check("post_rst_wrf", 32'(bus.W_RF), 0);
        check("post_rst_halted", 32'(bus.HALTED), 0);
        check_counters("post_rst");
    endtask

    // Starts in an IF cycle, ends in the IF cycle after the instruction (or in HALT).
    task automatic run_instr(input logic [2:0] t, input logic [4:0] o,
                             input int im_wait, input int dm_wait);
        exp_t e;
        e = model(t, o);
        bus.instr_type = t;
        bus.op         = o;
        bus.DM_READY   = 1'b0;
        for (int i = 0; i < im_wait; i++) begin
            bus.IM_READY = 1'b0;
            #1;
            check("if_wait_wpc", 32'(bus.W_PC), 0);
            tick();
        end
        bus.IM_READY = 1'b1;
        #1;
        check("if_wpc", 32'(bus.W_PC), 1);
        check_counters("if");
        tick();
        bus.IM_READY = 1'($urandom_range(0, 1));
        #1;
        check("id_wpc", 32'(bus.W_PC), 0);
        check("id_alu", 32'(bus.OP_ALU), 0);
        tick();
        if (e.halt) begin
            for (int k = 0; k < 4; k++) begin
                bus.IM_READY = 1'($urandom_range(0, 1));
                #1;
                check("halt_flag", 32'(bus.HALTED), 1);
                check("halt_wpc", 32'(bus.W_PC), 0);
                tick();
            end
            return;
        end
        bus.IM_READY = 1'b0;
        if (e.bad) begin
            ill_seen = 1'b1;
            #1;
            check("ill_wrb", 32'(bus.W_RB), 0);
            check("ill_alu", 32'(bus.OP_ALU), 0);
            check_counters("ill");
            return;
        end
        #1;
        check("ex_alu", 32'(bus.OP_ALU), 32'(e.alu));
        check("ex_tf", 32'(bus.OP_TF), 32'(e.tf));
        check("ex_se", 32'(bus.OP_SE), 32'(e.se));
        check("ex_mxse", 32'(bus.S_MXSE), 32'(e.mxse));
        check("ex_wrb", 32'(bus.W_RB), 0);
        tick();
        if (e.mem) begin
            for (int k = 0; k <= dm_wait; k++) begin
                bus.DM_READY = (k == dm_wait);
                #1;
                check("mem_wdm", 32'(bus.W_DM), 32'(e.dm));
                check("mem_alu", 32'(bus.OP_ALU), 32'(e.alu));
                check("mem_wrb", 32'(bus.W_RB), 0);
                tick();
            end
            bus.DM_READY = 1'b0;
            if (e.dm) begin
                retired++;
                return;
            end
        end
        #1;
        check("wb_wrb", 32'(bus.W_RB), 32'(e.rb));
        check("wb_wrf", 32'(bus.W_RF), 32'(e.rf));
        check("wb_mxrb", 32'(bus.S_MXRB), 32'(e.mxrb));
        check("wb_alu", 32'(bus.OP_ALU), 0);
        check("wb_wdm", 32'(bus.W_DM), 0);
        check("wb_wim", 32'(bus.W_IM), 0);
        retired++;
        tick();
    endtask

    initial begin
        logic [2:0] types [8];
        logic [2:0] t;
        logic [4:0] o;
        types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110, 3'b001, 3'b100, 3'b011};
        bus.instr_type = 3'b000;
        bus.op         = '0;
        do_reset();

        run_instr(3'b001, 5'b00010, 0, 0);   // ALU: W_RF class 100
        run_instr(3'b100, 5'b00000, 0, 3);   // load, four MEM cycles
        run_instr(3'b100, 5'b10000, 0, 2);   // store, three W_DM cycles
        run_instr(3'b010, 5'b01101, 5, 0);   // constant after five IF wait cycles
        run_instr(3'b000, 5'b10100, 1, 0);   // branch
        run_instr(3'b011, 5'b00001, 0, 0);   // illegal class
        run_instr(3'b101, 5'b00001, 0, 0);
        run_instr(3'b111, 5'b11111, 0, 0);   // halt
        do_reset();

        run_instr(3'b110, 5'b11000, 0, 0);   // jal
        run_instr(3'b110, 5'b01000, 0, 0);   // plain jump
        for (int i = 0; i < 3; i++) run_instr(3'b001, 5'(i * 9 + 7), 0, 0);
        #1;
        check("cnt2_wrap", 32'(bus2.INSTR_CNT), 1);

        // Abort a store mid-MEM with reset.
        bus.instr_type = 3'b100;
        bus.op         = 5'b10000;
        bus.IM_READY   = 1'b1;
        bus.DM_READY   = 1'b0;
        tick();
        bus.IM_READY = 1'b0;
        tick();
        tick();
        #1;
        check("abort_mem_wdm", 32'(bus.W_DM), 1);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            t = types[$urandom_range(0, 7)];
            o = 5'($urandom);
            if ($urandom_range(0, 9) == 0) t = 3'b111;
            if (t == 3'b111 && o == 5'b11111) o = 5'b01111;
            run_instr(t, o, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        #1;
        check_counters("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/unit_control_mc.md
Name: unit_control_mc

Overview:
- Parametrised multicycle control unit; successor to the fixed 4-state IF/ID/EX/WB controller.
- Decodes type/op into datapath control signals.
- Adds instruction- and data-memory ready handshakes with wait states, a dedicated MEM state, HALT and illegal-type detection, and a retired-instruction counter.
- Sits between the instruction register and the datapath (ALU, test-flag unit, sign extender, register bank, flag register, memories).

Parameters:
- OP_W, 5: width of op and OP_ALU; must be >= 5. Decode uses op[4:0]; the full op passes to OP_ALU.
- CNT_W, 16: width of the retired-instruction counter.
- HALT_OP, 5'b11111: op[4:0] value that, with type 3'b111, halts the unit.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- type  in  3  instruction class.
- op  in  OP_W  instruction operation field.
- IM_READY  in  1  instruction memory has valid data this cycle.
- DM_READY  in  1  data memory has completed the access this cycle.
- OP_ALU  out  OP_W  ALU operation.
- OP_TF  out  3  test-flag condition; 3'b111 means none.
- OP_SE  out  1  sign-extend mode.
- W_PC, W_DM, W_IM, W_RB  out  1 each  write enables.
- W_RF  out  3  flag-update class.
- S_MXRB  out  2  register-bank write-data select.
- S_MXSE  out  1  ALU operand-B select.
- HALTED  out  1  unit is in HALT.
- ILLEGAL  out  1  sticky flag: an illegal type was decoded.
- INSTR_CNT  out  CNT_W  retired-instruction count.

Behaviour:
- States (3-bit encoding): IF, ID, EX, MEM, WB, HALT.
- Default values: every output not driven by the current state takes OP_ALU=0, OP_TF=3'b111, and 0 for all other outputs.

Reset:
- RESET is sampled on the rising CLK edge.
- Reset clears STATE to IF, all latched decode registers to defaults, ILLEGAL to 0 and INSTR_CNT to 0.
- While RESET is high, all outputs hold their defaults (W_PC=0).
- Reset asserted in any state, including MEM mid-access and HALT, aborts the instruction. No write enable is asserted in the cycle after reset.

IF:
- W_PC = IM_READY.
- Stay in IF while IM_READY=0; go to ID on IM_READY=1.

ID:
- All outputs at defaults.
- Latch the decode registers from type/op (table below).
- Next state: HALT for type=3'b111 with op[4:0]==HALT_OP. Otherwise, for an illegal type (011, 101, or 111 with any other op), set ILLEGAL and go to IF without retiring. Otherwise go to EX.

EX:
- Drive latched OP_ALU, OP_TF, OP_SE, S_MXSE.
- Memory class goes to MEM; all other classes go to WB.

MEM:
- Hold the EX outputs.
- Store: W_DM=1 every cycle until DM_READY.
- Load: wait for DM_READY.
- On DM_READY: store goes to IF and retires; load goes to WB. No timeout.

WB:
- Drive latched S_MXRB, W_RF, W_RB for exactly one cycle.
- Go to IF and retire.

HALT:
- HALTED=1, all other outputs at defaults.
- Exit only via RESET.

Retire:
- INSTR_CNT increments by 1 on leaving WB, or on leaving MEM for a store.
- Wraps modulo 2^CNT_W.

Decode table (op here means op[4:0]):
- ALU (001): OP_ALU=op, OP_TF=111, W_RB=1, S_MXRB=10, S_MXSE=0.
  - W_RF: op==11111 gives 000; op==10000 gives 001; op[4:3]==01 gives 011; op[4:3]==00 gives 100; otherwise 010.
- Constant (010): OP_SE=1, OP_ALU=op, W_RB=1, W_RF=000, S_MXSE=1, S_MXRB=10.
- Memory (100): W_RB=~op[4] (load), W_DM=op[4] (store), W_RF=000, S_MXRB=01, S_MXSE=0.
- Branch (000): OP_ALU=10011, OP_TF={op[2],op[3],op[4]}, S_MXSE=1, no writes.
- Jump (110): OP_ALU=10011, OP_TF={op[2],op[3],op[4]}, S_MXSE=0, S_MXRB=00.
  - W_RB=1 only when {op[2],op[3],op[4]}==011 (jal).
- W_IM is always 0; it is reserved for a future loader.

Decomposition:
- Package unit_control_pkg holds:
  - state encodings;
  - type codes (TYPE_ALU, TYPE_CONST, TYPE_MEM, TYPE_BR, TYPE_JMP, TYPE_SYS);
  - W_RF class constants;
  - S_MXRB select constants;
  - TF_NONE=3'b111.
- One sub-module, unit_control_decode: purely combinational type/op to control bundle. The FSM top latches its output in ID.

Test Plan:
- ALU op=00010, IM_READY=1, DM_READY=1 → IF→ID→EX→WB. EX cycle: OP_ALU=00010. WB cycle: W_RF=100, W_RB=1, S_MXRB=10. INSTR_CNT 0→1.
- Load (type 100, op=00000) with DM_READY low 3 cycles → MEM held 4 cycles, W_DM=0, then WB with W_RB=1, S_MXRB=01.
- Store (op=10000) with DM_READY low 2 cycles → W_DM=1 for 3 cycles, returns to IF with no WB, INSTR_CNT+1.
- IM_READY low 5 cycles → W_PC=0 throughout, state stays IF. W_PC=1 exactly in the IM_READY=1 cycle.
- type=011 → ILLEGAL=1 (sticky), no W_RB/W_DM/W_RF asserted, INSTR_CNT unchanged. Then type 111 op 11111 → HALTED=1 forever; RESET returns to IF with HALTED=0, ILLEGAL=0, INSTR_CNT=0.
- CNT_W=2: retire 5 instructions → INSTR_CNT=1. Jump type 110 op=11000 (TF=011) → W_RB=1 in WB; op=01000 → W_RB=0. RESET asserted in MEM → no write in the following cycle.
